// File: rtl/fwd_pkg.sv
// fwd_pkg: shared tag/mode types for the EX forwarding and load-use hazard control.
package fwd_pkg;
    localparam int RD_W = 5;
    localparam int STAT_W = 32;
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            vec;
        logic            wen;
        logic            load;
    } stage_tag_t;
    typedef enum logic {FWD_M = 1'b0, FWD_WB = 1'b1} fwd_mode_e;
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage request and forward/stall response bundle.
// Statistics counters appear only when FWD_STATS_EN is defined.
interface fwd_hazard_ctrl_if #(parameter int REG_W = 5);
    import fwd_pkg::*;
    logic             advance, flush, id_valid, id_vec, id_wen, id_load;
    logic [REG_W-1:0] id_rd, id_src_a, id_src_b;
    logic             id_src_a_vec, id_src_b_vec, id_src_a_used, id_src_b_used;
    logic             stall, fwd_a_en, fwd_b_en, fwd_a_mode, fwd_b_mode;
`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] stat_fwd_m, stat_fwd_wb, stat_stall;
`endif
    modport master (
        output advance, flush, id_valid, id_rd, id_vec, id_wen, id_load,
               id_src_a, id_src_b, id_src_a_vec, id_src_b_vec, id_src_a_used, id_src_b_used,
`ifdef FWD_STATS_EN
        input  stat_fwd_m, stat_fwd_wb, stat_stall,
`endif
        input  stall, fwd_a_en, fwd_b_en, fwd_a_mode, fwd_b_mode
    );
    modport slave (
        input  advance, flush, id_valid, id_rd, id_vec, id_wen, id_load,
               id_src_a, id_src_b, id_src_a_vec, id_src_b_vec, id_src_a_used, id_src_b_used,
`ifdef FWD_STATS_EN
        output stat_fwd_m, stat_fwd_wb, stat_stall,
`endif
        output stall, fwd_a_en, fwd_b_en, fwd_a_mode, fwd_b_mode
    );
endinterface

// File: rtl/fwd_operand_cmp.sv
// fwd_operand_cmp: matches one ID source operand against the EX and M producer tags.
module fwd_operand_cmp import fwd_pkg::*; #(
    parameter int REG_W    = 5,
    parameter bit ZERO_REG = 1
) (
    input  stage_tag_t       ex_tag,
    input  stage_tag_t       m_tag,
    input  logic             id_valid,
    input  logic             used,
    input  logic             src_vec,
    input  logic [REG_W-1:0] src,
    output logic             en,
    output fwd_mode_e        mode,
    output logic             load_hit
);
    logic ex_hit, m_hit, unused;
    function automatic logic hit(input stage_tag_t t, input logic [RD_W-1:0] s, input logic sv, input logic u);
        return t.valid && t.wen && u && t.rd == s && t.vec == sv && !(ZERO_REG && !t.vec && t.rd == '0);
    endfunction
    assign ex_hit   = id_valid && hit(ex_tag, RD_W'(src), src_vec, used);
    assign m_hit    = id_valid && hit(m_tag, RD_W'(src), src_vec, used);
    assign en       = ex_hit || m_hit;
    assign mode     = (!ex_hit && m_hit) ? FWD_WB : FWD_M;
    assign load_hit = ex_hit && ex_tag.load;
    assign unused   = m_tag.load;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: shadow EX/M tag pipeline driving registered forward selects and load-use stall.
// Optional FWD_STATS_EN adds wrapping forward/stall event counters.
module fwd_hazard_ctrl import fwd_pkg::*; #(
    parameter int REG_W    = 5,
    parameter bit ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_ctrl_if.slave bus
);
    stage_tag_t ex_tag, m_tag, id_tag;
    logic       a_en, b_en, a_ld, b_ld, stall, a_en_q, b_en_q;
    fwd_mode_e  a_mode, b_mode, a_mode_q, b_mode_q;
    fwd_operand_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_a (
        .ex_tag(ex_tag), .m_tag(m_tag), .id_valid(bus.id_valid), .used(bus.id_src_a_used),
        .src_vec(bus.id_src_a_vec), .src(bus.id_src_a), .en(a_en), .mode(a_mode), .load_hit(a_ld)
    );
    fwd_operand_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_b (
        .ex_tag(ex_tag), .m_tag(m_tag), .id_valid(bus.id_valid), .used(bus.id_src_b_used),
        .src_vec(bus.id_src_b_vec), .src(bus.id_src_b), .en(b_en), .mode(b_mode), .load_hit(b_ld)
    );
    assign stall  = a_ld || b_ld;
    assign id_tag = '{valid: bus.id_valid, rd: RD_W'(bus.id_rd), vec: bus.id_vec, wen: bus.id_wen, load: bus.id_load};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag   <= '0;
            m_tag    <= '0;
            a_en_q   <= 1'b0;
            b_en_q   <= 1'b0;
            a_mode_q <= FWD_M;
            b_mode_q <= FWD_M;
        end else if (bus.flush) begin
            ex_tag.valid <= 1'b0;
            m_tag.valid  <= 1'b0;
            a_en_q       <= 1'b0;
            b_en_q       <= 1'b0;
        end else if (bus.advance) begin
            m_tag    <= ex_tag;
            ex_tag   <= stall ? '0 : id_tag;
            a_en_q   <= a_en && !stall;
            b_en_q   <= b_en && !stall;
            a_mode_q <= a_mode;
            b_mode_q <= b_mode;
        end
    end
    assign bus.stall      = stall;
    assign bus.fwd_a_en   = a_en_q;
    assign bus.fwd_b_en   = b_en_q;
    assign bus.fwd_a_mode = a_mode_q;
    assign bus.fwd_b_mode = b_mode_q;
`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] cnt_m, cnt_wb, cnt_st;
    logic              a_fm, a_fwb, b_fm, b_fwb;
    assign a_fm  = a_en && !stall && a_mode == FWD_M;
    assign a_fwb = a_en && !stall && a_mode == FWD_WB;
    assign b_fm  = b_en && !stall && b_mode == FWD_M;
    assign b_fwb = b_en && !stall && b_mode == FWD_WB;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m  <= '0;
            cnt_wb <= '0;
            cnt_st <= '0;
        end else if (bus.advance && !bus.flush) begin
            cnt_m  <= cnt_m + STAT_W'(a_fm) + STAT_W'(b_fm);
            cnt_wb <= cnt_wb + STAT_W'(a_fwb) + STAT_W'(b_fwb);
            cnt_st <= cnt_st + STAT_W'(stall);
        end
    end
    assign bus.stat_fwd_m  = cnt_m;
    assign bus.stat_fwd_wb = cnt_wb;
    assign bus.stat_stall  = cnt_st;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed vector table plus hand sequences for the forwarding/hazard controller.
module tb_fwd_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    fwd_hazard_ctrl_if #(.REG_W(5)) bus ();
    fwd_hazard_ctrl #(.REG_W(5), .ZERO_REG(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        int adv, fl, v, rd, vec, wen, ld;
        int sa, sav, sau, sb, sbv, sbu;
        int st, ae, am, be, bm;
    } vec_t;
    vec_t tbl[22];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic drive(input vec_t t);
        bus.advance       = 1'(t.adv);
        bus.flush         = 1'(t.fl);
        bus.id_valid      = 1'(t.v);
        bus.id_rd         = 5'(t.rd);
        bus.id_vec        = 1'(t.vec);
        bus.id_wen        = 1'(t.wen);
        bus.id_load       = 1'(t.ld);
        bus.id_src_a      = 5'(t.sa);
        bus.id_src_a_vec  = 1'(t.sav);
        bus.id_src_a_used = 1'(t.sau);
        bus.id_src_b      = 5'(t.sb);
        bus.id_src_b_vec  = 1'(t.sbv);
        bus.id_src_b_used = 1'(t.sbu);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, " stall"}, 32'(bus.stall), 0);
        chk({nm, " a_en"}, 32'(bus.fwd_a_en), 0);
        chk({nm, " a_mode"}, 32'(bus.fwd_a_mode), 0);
        chk({nm, " b_en"}, 32'(bus.fwd_b_en), 0);
        chk({nm, " b_mode"}, 32'(bus.fwd_b_mode), 0);
`ifdef FWD_STATS_EN
        chk({nm, " stat_m"}, bus.stat_fwd_m, 0);
        chk({nm, " stat_wb"}, bus.stat_fwd_wb, 0);
        chk({nm, " stat_stall"}, bus.stat_stall, 0);
`endif
    endtask
    initial begin
        vec_t t;
        //          adv fl v  rd vec wen ld  sa sav sau  sb sbv sbu  st  ae am be bm
        tbl = '{
            '{1,0,1, 3,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1,10,0,1,0,  3,0,1,  0,0,0, 0, 1,0,0,0},
            '{1,0,1, 7,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1, 8,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1, 9,0,0,0,  0,0,0,  7,0,1, 0, 0,0,1,1},
            '{1,0,1, 4,0,1,1,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1,11,0,0,0,  4,0,1,  0,0,0, 1, 0,0,0,0},
            '{1,0,1,11,0,0,0,  4,0,1,  0,0,0, 0, 1,1,0,0},
            '{1,0,1, 5,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1, 5,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1,13,0,0,0,  5,0,1,  5,0,1, 0, 1,0,1,0},
            '{0,0,0, 0,0,0,0,  5,0,1,  5,0,1, 0, 1,0,1,0},
            '{1,0,1, 2,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1,14,0,0,0,  2,1,1,  2,0,1, 0, 0,0,1,0},
            '{1,0,1, 0,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1,15,0,0,0,  0,0,1,  0,1,1, 0, 0,0,0,0},
            '{1,0,1, 0,1,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1,16,0,0,0,  0,0,1,  0,1,1, 0, 0,0,1,0},
            '{1,0,1,12,0,1,0,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{1,0,1, 6,0,1,1,  0,0,0,  0,0,0, 0, 0,0,0,0},
            '{0,1,1,17,0,0,0,  6,0,1, 12,0,1, 1, 0,0,0,0},
            '{1,0,1,17,0,0,0,  6,0,1, 12,0,1, 0, 0,0,0,0}
        };
        t = '{0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0};
        drive(t);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1 chk($sformatf("row%0d stall", i), 32'(bus.stall), tbl[i].st);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d a_en", i), 32'(bus.fwd_a_en), tbl[i].ae);
            chk($sformatf("row%0d a_mode", i), 32'(bus.fwd_a_mode), tbl[i].am);
            chk($sformatf("row%0d b_en", i), 32'(bus.fwd_b_en), tbl[i].be);
            chk($sformatf("row%0d b_mode", i), 32'(bus.fwd_b_mode), tbl[i].bm);
        end
`ifdef FWD_STATS_EN
        chk("stat_m", bus.stat_fwd_m, 5);
        chk("stat_wb", bus.stat_fwd_wb, 2);
        chk("stat_stall", bus.stat_stall, 1);
`endif
        // producer r1, then a load that forwards r1 from EX, then a consumer of the load
        @(negedge clk);
        t = '{1,0,1, 1,0,1,0, 0,0,0, 0,0,0, 0, 0,0,0,0};
        drive(t);
        @(negedge clk);
        t = '{1,0,1, 4,0,1,1, 1,0,1, 0,0,0, 0, 0,0,0,0};
        drive(t);
        @(posedge clk);
        #1 chk("pre_rst a_en", 32'(bus.fwd_a_en), 1);
        @(negedge clk);
        t = '{1,0,1, 9,0,0,0, 4,0,1, 0,0,0, 0, 0,0,0,0};
        drive(t);
        #1 chk("pre_rst stall", 32'(bus.stall), 1);
        #1 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
